// File: rtl/button_debouncer.sv
// Push-button conditioner: per-bit 2-flop synchronizer, polarity normalisation,
// counter-based debounce and registered single-cycle press/release pulses.
module button_debouncer #(
  parameter int BUTTON_COUNT    = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                    clock_50mhz,
  input  logic                    reset,
  input  logic [BUTTON_COUNT-1:0] raw_buttons,
  output logic [BUTTON_COUNT-1:0] buttons_level,
  output logic [BUTTON_COUNT-1:0] buttons_pressed,
  output logic [BUTTON_COUNT-1:0] buttons_released
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);
  localparam logic [BUTTON_COUNT-1:0] RELEASED_RAW = {BUTTON_COUNT{POL}};

  typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

  logic [BUTTON_COUNT-1:0] r_sync1;
  logic [BUTTON_COUNT-1:0] r_sync2;
  logic [BUTTON_COUNT-1:0] w_sample;

  state_t        r_state      [BUTTON_COUNT];
  state_t        w_state_next [BUTTON_COUNT];
  logic [CW-1:0] r_count      [BUTTON_COUNT];
  logic [CW-1:0] w_count_next [BUTTON_COUNT];

  logic [BUTTON_COUNT-1:0] w_level_next;
  logic [BUTTON_COUNT-1:0] w_pressed_next;
  logic [BUTTON_COUNT-1:0] w_released_next;

  // Synchronizer resets to the idle raw level so no phantom edge follows reset.
  always_ff @(posedge clock_50mhz or posedge reset) begin
    if (reset) begin
      r_sync1 <= RELEASED_RAW;
      r_sync2 <= RELEASED_RAW;
    end else begin
      r_sync1 <= raw_buttons;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2 ^ RELEASED_RAW;

  generate
    for (genvar gi = 0; gi < BUTTON_COUNT; gi++) begin : g_bit
      state_t        w_state_bit;
      logic [CW-1:0] w_count_bit;
      logic          w_level_bit;
      logic          w_pressed_bit;
      logic          w_released_bit;

      always_comb begin
        w_state_bit    = r_state[gi];
        w_count_bit    = r_count[gi];
        w_level_bit    = buttons_level[gi];
        w_pressed_bit  = 1'b0;
        w_released_bit = 1'b0;
        case (r_state[gi])
          ST_STABLE: begin
            w_count_bit = '0;
            if (w_sample[gi] != buttons_level[gi]) begin
              w_state_bit = ST_COUNTING;
              w_count_bit = CW'(1);
            end
          end
          ST_COUNTING: begin
            if (w_sample[gi] == buttons_level[gi]) begin
              w_state_bit = ST_STABLE;
              w_count_bit = '0;
            end else if (r_count[gi] == LAST) begin
              // New level has held for the full window: accept it.
              w_level_bit    = w_sample[gi];
              w_pressed_bit  = w_sample[gi];
              w_released_bit = ~w_sample[gi];
              w_state_bit    = ST_STABLE;
              w_count_bit    = '0;
            end else begin
              w_count_bit = r_count[gi] + CW'(1);
            end
          end
          default: begin
            w_state_bit = ST_STABLE;
            w_count_bit = '0;
          end
        endcase
      end

      assign w_state_next[gi]    = w_state_bit;
      assign w_count_next[gi]    = w_count_bit;
      assign w_level_next[gi]    = w_level_bit;
      assign w_pressed_next[gi]  = w_pressed_bit;
      assign w_released_next[gi] = w_released_bit;
    end
  endgenerate

  always_ff @(posedge clock_50mhz or posedge reset) begin
    if (reset) begin
      buttons_level    <= '0;
      buttons_pressed  <= '0;
      buttons_released <= '0;
      for (int i = 0; i < BUTTON_COUNT; i++) begin
        r_state[i] <= ST_STABLE;
        r_count[i] <= '0;
      end
    end else begin
      buttons_level    <= w_level_next;
      buttons_pressed  <= w_pressed_next;
      buttons_released <= w_released_next;
      for (int i = 0; i < BUTTON_COUNT; i++) begin
        r_state[i] <= w_state_next[i];
        r_count[i] <= w_count_next[i];
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised + directed bench for button_debouncer; a run-length reference model
// feeds a scoreboard queue that a negedge monitor drains and compares.
module tb_button_debouncer;
  localparam int N = 4;
  localparam int D = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] lvl;
  logic [N-1:0] prs;
  logic [N-1:0] rls;

  int n_checks = 0;
  int n_pass   = 0;

  button_debouncer #(.BUTTON_COUNT(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut (
    .clock_50mhz      (clk),
    .reset            (rst),
    .raw_buttons      (raw),
    .buttons_level    (lvl),
    .buttons_pressed  (prs),
    .buttons_released (rls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
  endtask

  // Reference model: a bit's accepted level flips once the pressed value seen two
  // edges after the raw pin has differed from it for D consecutive edges.
  logic [3*N-1:0] exp_q[$];
  logic [N-1:0]   m_p1, m_p2, m_level;
  int             m_run [N];

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] s, pr, rl;
    if (rst) begin
      m_p1 = '0;
      m_p2 = '0;
      m_level = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      exp_q.delete();
    end else begin
      s = m_p2;
      m_p2 = m_p1;
      m_p1 = ~raw;
      pr = '0;
      rl = '0;
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_level[i] = s[i];
            pr[i] = s[i];
            rl[i] = ~s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      exp_q.push_back({m_level, pr, rl});
    end
  end

  always @(negedge clk) begin
    logic [3*N-1:0] e;
    if (rst) begin
      chk("outputs_in_reset", 32'({lvl, prs, rls}), 32'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle_outputs", 32'({lvl, prs, rls}), 32'(e));
      if ((prs | rls) != '0)
        $display("t=%0t edge: pressed=%b released=%b level=%b", $time, prs, rls, lvl);
    end
  end

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic pulse_reset(input int hold);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_clear", 32'({lvl, prs, rls}), 32'd0);
    repeat (hold) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Expects a press pulse on bit b exactly on the 10th edge from now.
  task automatic expect_press_10(input int b);
    repeat (D + 1) @(posedge clk);
    #1 chk("level_before_accept", 32'(lvl[b]), 32'd0);
    @(posedge clk);
    #1 chk("press_at_edge_10", 32'({lvl[b], prs[b], rls[b]}), 32'b110);
    @(posedge clk);
    #1 chk("press_one_cycle", 32'(prs[b]), 32'd0);
  endtask

  initial begin
    logic [N-1:0] v;
    rst = 1'b1;
    raw = '1;
    idle(3);
    #2 rst = 1'b0;
    idle(4);

    // Clean press on bit 0.
    drive(4'b1110);
    expect_press_10(0);
    idle(5);

    // Bouncing bit 1, then settles pressed.
    v = 4'b1110;
    for (int k = 0; k < 10; k++) begin
      v[1] = ~v[1];
      drive(v);
      idle(2);
    end
    v[1] = 1'b0;
    drive(v);
    idle(15);

    // Glitches on bit 2: 7 cycles rejected, 8 cycles accepted then released.
    v[2] = 1'b0; drive(v); idle(6);
    v[2] = 1'b1; drive(v); idle(15);
    chk("short_glitch_level", 32'(lvl[2]), 32'd0);
    v[2] = 1'b0; drive(v); idle(7);
    v[2] = 1'b1; drive(v); idle(15);

    // Key 3 held through reset: fresh press after deassertion.
    v[3] = 1'b0;
    drive(v);
    pulse_reset(3);
    expect_press_10(3);
    idle(5);

    // Reset mid-count on bit 0, with bit 1 still accepted-pressed.
    drive(4'b1101);
    idle(15);
    drive(4'b1100);
    repeat (D - 1) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("mid_count_reset_clear", 32'({lvl, prs, rls}), 32'd0);
    idle(2);
    #2 rst = 1'b0;
    expect_press_10(0);
    idle(5);

    // All four bits in parallel.
    drive(4'b1111);
    idle(15);
    drive(4'b0000);
    repeat (D + 2) @(posedge clk);
    #1 chk("parallel_press", 32'({prs, rls}), 32'hF0);
    idle(12);
    drive(4'b1010);
    repeat (D + 2) @(posedge clk);
    #1 chk("parallel_release", 32'({lvl, prs, rls}), 32'h50A);
    idle(12);

    // Randomised segments mixing heavy bounce and quiet stretches.
    v = raw;
    for (int seg = 0; seg < 40; seg++) begin
      int lim;
      lim = ($urandom_range(1) == 0) ? 2 : 24;
      for (int c = 0; c < 60; c++) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(lim) == 0) v[b] = ~v[b];
        drive(v);
        if ($urandom_range(299) == 0) pulse_reset(1 + $urandom_range(2));
      end
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
